// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution accumulator bank.
package conv_pkg;

  // Top-level control states: waiting, collecting taps, streaming results out.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } conv_state_t;

  // Widest value the saturation helper works on; accumulators must fit in it.
  localparam int SAT_WIDE_W = 64;

  // Address width for a table of 'depth' entries, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Clamp a sign-extended accumulator sum into the signed range of out_w bits.
  // With sat_en low the value passes through and the caller keeps the low bits.
  function automatic logic signed [SAT_WIDE_W-1:0] sat_s(
    input logic signed [SAT_WIDE_W-1:0] value,
    input int                           out_w,
    input logic                         sat_en
  );
    logic signed [SAT_WIDE_W-1:0] hi_lim;
    logic signed [SAT_WIDE_W-1:0] lo_lim;
    hi_lim = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo_lim = -(64'sd1 <<< (out_w - 1));
    sat_s  = value;
    if (sat_en) begin
      if (value > hi_lim) begin
        sat_s = hi_lim;
      end else if (value < lo_lim) begin
        sat_s = lo_lim;
      end
    end
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output channel: signed multiply-accumulate over KER_N taps, then bias add
// and saturation/wrap. The result is combinational so the owner can store it on
// the same edge that accepts the final tap of a position.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter int SAT_EN = 1
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] img,
  input  logic signed [DATA_W-1:0] wei,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [OUT_W-1:0]  res
);

  logic signed [ACC_W-1:0]      acc_reg;
  logic signed [2*DATA_W-1:0]   prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      bias_ext;
  logic signed [ACC_W-1:0]      sum;
  logic signed [SAT_WIDE_W-1:0] sum_wide;
  logic signed [SAT_WIDE_W-1:0] sat_wide;

  // Full-precision product, position sum including bias, and output folding.
  always_comb begin
    prod     = (2*DATA_W)'(img) * (2*DATA_W)'(wei);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'(bias);
    sum      = acc_reg + prod_ext + bias_ext;
    sum_wide = SAT_WIDE_W'(sum);
    sat_wide = sat_s(sum_wide, OUT_W, SAT_EN != 0);
    res      = sat_wide[OUT_W-1:0];
  end

  // Accumulate on every accepted tap; the last tap of a position restarts at zero.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= last ? '0 : acc_reg + prod_ext;
    end
  end

endmodule

// File: rtl/conv_acc_bank.sv
// Multi-channel convolution result collector: CH MAC lanes fill a result buffer
// position by position, then the buffer is streamed out as a valid/ready drain.
module conv_acc_bank
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 2,
  parameter int KER_N  = 4,
  parameter int RES_W  = 3,
  parameter int RES_H  = 3,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter int SAT_EN = 1
) (
  input  logic                                     sys_clk_i,
  input  logic                                     sys_rst_i,
  input  logic                                     start_i,
  input  logic                                     pix_valid_i,
  output logic                                     pix_ready_o,
  input  logic [DATA_W-1:0]                        img_i,
  input  logic [CH*DATA_W-1:0]                     wei_i,
  input  logic [CH*DATA_W-1:0]                     bias_i,
  output logic                                     rd_valid_o,
  input  logic                                     rd_ready_i,
  output logic [CH*OUT_W-1:0]                      rd_data_o,
  output logic [addr_w(RES_W*RES_H)-1:0]           rd_addr_o,
  output logic                                     busy_o,
  output logic                                     done_o
);

  localparam int RES_N  = RES_W * RES_H;
  localparam int ADDR_W = addr_w(RES_N);
  localparam int TAP_W  = addr_w(KER_N);

  // Accumulator must hold KER_N full products plus a bias without overflow.
  if (ACC_W < 2*DATA_W + $clog2(KER_N) + 1) begin : g_acc_w_check
    $error("conv_acc_bank: ACC_W too narrow for DATA_W and KER_N");
  end
  if (ACC_W > SAT_WIDE_W) begin : g_acc_w_max_check
    $error("conv_acc_bank: ACC_W exceeds saturation helper width");
  end

  conv_state_t           state_reg;
  logic [TAP_W-1:0]      tap_cnt_reg;
  logic [ADDR_W-1:0]     pos_cnt_reg;
  logic                  rd_valid_reg;
  logic [ADDR_W-1:0]     rd_addr_reg;
  logic [CH*OUT_W-1:0]   rd_data_reg;
  logic                  done_reg;
  logic [CH*OUT_W-1:0]   mem [RES_N];

  logic                  accept;
  logic                  last_tap;
  logic                  last_pos;
  logic                  wr_en;
  logic [CH*OUT_W-1:0]   lane_res;
  logic                  drain_accept;
  logic                  drain_last;
  logic [ADDR_W-1:0]     rd_raddr;
  logic [CH*OUT_W-1:0]   rd_rdata;

  assign accept       = pix_valid_i && (state_reg == ST_ACC);
  assign last_tap     = (tap_cnt_reg == TAP_W'(KER_N - 1));
  assign last_pos     = (pos_cnt_reg == ADDR_W'(RES_N - 1));
  assign wr_en        = accept && last_tap && !start_i;
  assign drain_accept = rd_valid_reg && rd_ready_i;
  assign drain_last   = (rd_addr_reg == ADDR_W'(RES_N - 1));

  // Next buffer address to read: beat 0 when a drain begins, else the following beat.
  // A same-edge write to that address is forwarded so a one-entry map still works.
  always_comb begin
    rd_raddr = (state_reg == ST_ACC) ? '0 : rd_addr_reg + 1'b1;
    rd_rdata = (wr_en && (pos_cnt_reg == rd_raddr)) ? lane_res : mem[rd_raddr];
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    conv_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SAT_EN (SAT_EN)
    ) u_lane (
      .clk  (sys_clk_i),
      .srst (sys_rst_i),
      .clr  (start_i),
      .en   (accept),
      .last (last_tap),
      .img  (img_i),
      .wei  (wei_i[gi*DATA_W +: DATA_W]),
      .bias (bias_i[gi*DATA_W +: DATA_W]),
      .res  (lane_res[gi*OUT_W +: OUT_W])
    );
  end

  // Result buffer: one word per position holding every channel's result.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      for (int i = 0; i < RES_N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[pos_cnt_reg] <= lane_res;
    end
  end

  // Control FSM: tap/position counting, drain sequencing, abort on start.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_reg    <= ST_IDLE;
      tap_cnt_reg  <= '0;
      pos_cnt_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      rd_data_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      // The final beat's done pulse survives a coincident restart.
      done_reg <= drain_accept && drain_last;
      if (start_i) begin
        state_reg    <= ST_ACC;
        tap_cnt_reg  <= '0;
        pos_cnt_reg  <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
          end
          ST_ACC: begin
            if (accept) begin
              if (last_tap) begin
                tap_cnt_reg <= '0;
                if (last_pos) begin
                  state_reg    <= ST_DRAIN;
                  pos_cnt_reg  <= '0;
                  rd_valid_reg <= 1'b1;
                  rd_addr_reg  <= '0;
                  rd_data_reg  <= rd_rdata;
                end else begin
                  pos_cnt_reg <= pos_cnt_reg + 1'b1;
                end
              end else begin
                tap_cnt_reg <= tap_cnt_reg + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (drain_accept) begin
              if (drain_last) begin
                state_reg    <= ST_IDLE;
                rd_valid_reg <= 1'b0;
              end else begin
                rd_addr_reg <= rd_addr_reg + 1'b1;
                rd_data_reg <= rd_rdata;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign pix_ready_o = (state_reg == ST_ACC);
  assign busy_o      = (state_reg != ST_IDLE);
  assign rd_valid_o  = rd_valid_reg;
  assign rd_addr_o   = rd_addr_reg;
  assign rd_data_o   = rd_data_reg;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_conv_acc_bank.sv
// Bench for conv_acc_bank: a saturating and a wrapping instance share stimulus.
module tb_conv_acc_bank;

  localparam int NPOS = 9;
  localparam int NTAP = 4;
  localparam int NALL = NPOS * NTAP;

  logic        clk = 1'b0;
  logic        srst, start, pix_valid, rd_ready;
  logic [7:0]  img;
  logic [15:0] wei, bias;

  logic        pix_ready_s, rd_valid_s, busy_s, done_s;
  logic [31:0] rd_data_s;
  logic [3:0]  rd_addr_s;
  logic        pix_ready_w, rd_valid_w, busy_w, done_w;
  logic [31:0] rd_data_w;
  logic [3:0]  rd_addr_w;

  int n_checks = 0;
  int n_fail   = 0;

  int t_img[NALL], t_w0[NALL], t_w1[NALL], t_b0[NALL], t_b1[NALL];
  int exp_s[2][NPOS], exp_w[2][NPOS];

  typedef struct {
    int img, w0, w1, b0, b1;
    int gap;      // idle cycles before each tap
    int rdy_mode; // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int e0s, e1s, e0w, e1w;
  } vec_t;

  always #5 clk = ~clk;

  conv_acc_bank #(.SAT_EN(1)) dut_sat (
    .sys_clk_i(clk), .sys_rst_i(srst), .start_i(start), .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready_s), .img_i(img), .wei_i(wei), .bias_i(bias),
    .rd_valid_o(rd_valid_s), .rd_ready_i(rd_ready), .rd_data_o(rd_data_s),
    .rd_addr_o(rd_addr_s), .busy_o(busy_s), .done_o(done_s)
  );

  conv_acc_bank #(.SAT_EN(0)) dut_wrap (
    .sys_clk_i(clk), .sys_rst_i(srst), .start_i(start), .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready_w), .img_i(img), .wei_i(wei), .bias_i(bias),
    .rd_valid_o(rd_valid_w), .rd_ready_i(rd_ready), .rd_data_o(rd_data_w),
    .rd_addr_o(rd_addr_w), .busy_o(busy_w), .done_o(done_w)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Fold an exact integer sum into a 16-bit signed result.
  function automatic int fold(input longint s, input bit sat);
    logic signed [15:0] t;
    if (sat) begin
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
      return int'(s);
    end
    t = s[15:0];
    return int'(t);
  endfunction

  function automatic void fill_const(input vec_t v);
    for (int k = 0; k < NALL; k++) begin
      t_img[k] = v.img; t_w0[k] = v.w0; t_w1[k] = v.w1; t_b0[k] = v.b0; t_b1[k] = v.b1;
    end
    for (int p = 0; p < NPOS; p++) begin
      exp_s[0][p] = v.e0s; exp_s[1][p] = v.e1s;
      exp_w[0][p] = v.e0w; exp_w[1][p] = v.e1w;
    end
  endfunction

  function automatic void fill_rand();
    for (int k = 0; k < NALL; k++) begin
      t_img[k] = int'($urandom_range(0, 255)) - 128;
      t_w0[k]  = int'($urandom_range(0, 255)) - 128;
      t_w1[k]  = int'($urandom_range(0, 255)) - 128;
      t_b0[k]  = int'($urandom_range(0, 255)) - 128;
      t_b1[k]  = int'($urandom_range(0, 255)) - 128;
    end
  endfunction

  // Reference: per position, sum of products over its taps plus the bias seen on its last tap.
  function automatic void compute_model();
    longint s0, s1;
    for (int p = 0; p < NPOS; p++) begin
      s0 = 0; s1 = 0;
      for (int k = 0; k < NTAP; k++) begin
        s0 += longint'(t_img[p*NTAP+k]) * t_w0[p*NTAP+k];
        s1 += longint'(t_img[p*NTAP+k]) * t_w1[p*NTAP+k];
      end
      s0 += t_b0[p*NTAP+NTAP-1];
      s1 += t_b1[p*NTAP+NTAP-1];
      exp_s[0][p] = fold(s0, 1); exp_s[1][p] = fold(s1, 1);
      exp_w[0][p] = fold(s0, 0); exp_w[1][p] = fold(s1, 0);
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_pix_ready", pix_ready_s, 1);
    check("start_busy", busy_w, 1);
  endtask

  // Feed n taps; gap < 0 picks a random gap of 0..2 before each tap.
  task automatic feed_taps(input int n, input int gap);
    int g;
    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int j = 0; j < g; j++) begin
        pix_valid = 1'b0;
        img = 8'($urandom);
        check("gap_pix_ready", pix_ready_s, 1);
        @(negedge clk);
      end
      check("tap_pix_ready", pix_ready_s, 1);
      pix_valid = 1'b1;
      img  = 8'(t_img[k]);
      wei  = {8'(t_w1[k]), 8'(t_w0[k])};
      bias = {8'(t_b1[k]), 8'(t_b0[k])};
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  // Consume the drain; abort_at >= 0 restarts while that beat is accepted.
  task automatic drain_check(input int rdy_mode, input int abort_at);
    int beats = 0, dones = 0, cyc = 0, pi = 0;
    bit stalled_prev = 1'b0;
    bit rdy;
    logic [3:0]  prev_addr;
    logic [31:0] prev_data;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    check("first_beat_valid", rd_valid_s, 1);
    while (beats < NPOS && cyc < 300) begin
      if (done_s || done_w) dones++;
      check("drain_valid", rd_valid_s, 1);
      if (!rd_valid_s) break;
      if (stalled_prev) begin
        check("stall_addr", rd_addr_s, prev_addr);
        check("stall_data", rd_data_s, prev_data);
      end
      check("beat_addr_sat", rd_addr_s, beats);
      check("beat_addr_wrap", rd_addr_w, beats);
      check("beat_ch0_sat", int'($signed(rd_data_s[15:0])), exp_s[0][beats]);
      check("beat_ch1_sat", int'($signed(rd_data_s[31:16])), exp_s[1][beats]);
      check("beat_ch0_wrap", int'($signed(rd_data_w[15:0])), exp_w[0][beats]);
      check("beat_ch1_wrap", int'($signed(rd_data_w[31:16])), exp_w[1][beats]);
      case (rdy_mode)
        1:       rdy = pat[pi % 4];
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      pi++;
      pix_valid = 1'($urandom_range(0, 1));
      img = 8'($urandom);
      if (abort_at == beats) begin
        pix_valid = 1'b0;
        rd_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_ready = 1'b0;
        check("abort_valid_drop", rd_valid_s, 0);
        check("abort_no_done", done_s, 0);
        check("abort_in_acc", pix_ready_s, 1);
        check("abort_done_count", dones, 0);
        return;
      end
      rd_ready = rdy;
      stalled_prev = !rdy;
      prev_addr = rd_addr_s;
      prev_data = rd_data_s;
      if (rdy) beats++;
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0;
    rd_ready = 1'b0;
    check("drain_beats", beats, NPOS);
    check("early_done", dones, 0);
    check("done_pulse_sat", done_s, 1);
    check("done_pulse_wrap", done_w, 1);
    check("end_valid_low", rd_valid_s, 0);
    check("end_idle", busy_s, 0);
    @(negedge clk);
    check("done_one_cycle", done_s, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_ready"}, pix_ready_s | pix_ready_w, 0);
    check({tag, "_rd_valid"}, rd_valid_s | rd_valid_w, 0);
    check({tag, "_rd_data"}, rd_data_s | rd_data_w, 0);
    check({tag, "_rd_addr"}, rd_addr_s | rd_addr_w, 0);
    check({tag, "_busy"}, busy_s | busy_w, 0);
    check({tag, "_done"}, done_s | done_w, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v1, v2;
    v1 = '{1, 2, -1, 3, 0, 0, 0, 11, -4, 11, -4};
    v2 = '{2, 1, 1, 0, 0, 0, 0, 8, 8, 8, 8};
    vecs[0] = v1;
    vecs[1] = '{127, 127, -128, 0, 0, 0, 0, 32767, -32768, -1020, 512};
    vecs[2] = '{-128, -128, -128, 0, 0, 1, 0, 32767, 32767, 0, 0};
    vecs[3] = '{1, 2, -1, 3, 0, 2, 1, 11, -4, 11, -4};
    vecs[4] = '{-128, 127, -128, -128, 127, 0, 2, -32768, 32767, 384, 127};
    vecs[5] = '{1, 2, -1, 3, 0, 0, 1, 11, -4, 11, -4};

    srst = 1'b1; start = 1'b0; pix_valid = 1'b0; rd_ready = 1'b0;
    img = '0; wei = '0; bias = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    srst = 1'b0;

    // Taps offered while idle must be ignored.
    pix_valid = 1'b1; img = 8'd55; wei = 16'h7f7f; bias = 16'h7f7f;
    repeat (3) begin
      @(negedge clk);
      check("idle_pix_ready", pix_ready_s, 0);
      check("idle_busy", busy_s, 0);
    end
    pix_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill_const(vecs[i]);
      pulse_start();
      feed_taps(NALL, vecs[i].gap);
      drain_check(vecs[i].rdy_mode, -1);
      $display("vector %0d: img=%0d w0=%0d w1=%0d gap=%0d rdy_mode=%0d done, failures so far %0d",
               i, vecs[i].img, vecs[i].w0, vecs[i].w1, vecs[i].gap, vecs[i].rdy_mode, n_fail);
    end

    // Reset in the middle of accumulation, then a clean rerun.
    fill_const(v1);
    pulse_start();
    feed_taps(5 * NTAP, 0);
    srst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    srst = 1'b0;
    pulse_start();
    feed_taps(NALL, 0);
    drain_check(0, -1);
    $display("mid-ACC reset sequence done, failures so far %0d", n_fail);

    // Abort during drain beat 4, then a new frame.
    fill_const(v1);
    pulse_start();
    feed_taps(NALL, 0);
    drain_check(0, 4);
    fill_const(v2);
    feed_taps(NALL, 0);
    drain_check(0, -1);
    $display("drain abort sequence done, failures so far %0d", n_fail);

    // Random frames against the arithmetic model.
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      compute_model();
      pulse_start();
      feed_taps(NALL, -1);
      drain_check(2, -1);
      $display("random frame %0d done, failures so far %0d", r, n_fail);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
